heichips25_pwm_capture: RTL



---
 rtl/heichips25_pwm_capture.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/heichips25_pwm_capture.sv
// PWM capture receiver: measures high time and period on ui_in[0] and returns them as four bytes via an rd strobe.
// Build option: define PWM_CAPTURE_GLITCH_FILTER_EN to insert a 3-sample majority filter on pwm_in.
//
// state  | meaning
// S_IDLE | waiting for the first rising edge, no measurement running
// S_HIGH | pwm high: high and period counters both running
// S_LOW  | pwm low: high count frozen, period counter running
module heichips25_pwm_capture #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

    state_t state, state_nxt;
    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic pwm_s, rd_s, clr_s, pwm_f;
    logic pwm_q, rd_q, rise, fall, rd_p;
    logic [CNT_W-1:0] high_cnt, per_cnt;
    logic load, hi_inc, per_inc, publish, sat;
    logic [15:0] res_high, res_per;
    logic valid, ovf, missed, rd_last, accept;
    logic [1:0] idx;
    logic unused_pins;

    assign unused_pins = &{1'b0, uio_in, ui_in[7:3]};

    always_ff @(posedge clk) begin
        if (!rst_n) sync_q <= '0;
        else if (ena) sync_q <= {sync_q[SYNC_STAGES-2:0], ui_in[2:0]};
    end

    assign pwm_s = sync_q[SYNC_STAGES-1][0];
    assign rd_s  = sync_q[SYNC_STAGES-1][1];
    assign clr_s = sync_q[SYNC_STAGES-1][2];

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    logic [1:0] flt_q;
    always_ff @(posedge clk) begin
        if (!rst_n) flt_q <= '0;
        else if (ena) flt_q <= {flt_q[0], pwm_s};
    end
    assign pwm_f = (pwm_s & flt_q[0]) | (pwm_s & flt_q[1]) | (flt_q[0] & flt_q[1]);
`else
    assign pwm_f = pwm_s;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_q <= 1'b0;
            rd_q  <= 1'b0;
        end else if (ena) begin
            pwm_q <= pwm_f;
            rd_q  <= rd_s;
        end
    end

    assign rise = pwm_f & ~pwm_q;
    assign fall = ~pwm_f & pwm_q;
    assign rd_p = rd_s & ~rd_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else if (ena) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        hi_inc    = 1'b0;
        per_inc   = 1'b0;
        publish   = 1'b0;
        sat       = 1'b0;
        case (state)
            S_IDLE: begin
                if (rise) begin
                    load      = 1'b1;
                    state_nxt = S_HIGH;
                end
            end
            S_HIGH: begin
                if (per_cnt == CNT_MAX) begin
                    sat       = 1'b1;
                    publish   = 1'b1;
                    state_nxt = S_IDLE;
                end else if (fall) begin
                    per_inc   = 1'b1;
                    state_nxt = S_LOW;
                end else begin
                    hi_inc  = 1'b1;
                    per_inc = 1'b1;
                end
            end
            S_LOW: begin
                // A closing rise wins over saturation: the period is exactly CNT_MAX
                if (rise) begin
                    publish   = 1'b1;
                    load      = 1'b1;
                    state_nxt = S_HIGH;
                end else if (per_cnt == CNT_MAX) begin
                    sat       = 1'b1;
                    publish   = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    per_inc = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (clr_s) begin
            state_nxt = S_IDLE;
            load      = 1'b0;
            hi_inc    = 1'b0;
            per_inc   = 1'b0;
            publish   = 1'b0;
            sat       = 1'b0;
        end
    end

    // The final read of a result frees the register for a publish in the same cycle
    assign rd_last = rd_p & valid & (idx == 2'd3);
    assign accept  = ~valid | rd_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            high_cnt <= '0;
            per_cnt  <= '0;
            res_high <= '0;
            res_per  <= '0;
            valid    <= 1'b0;
            ovf      <= 1'b0;
            missed   <= 1'b0;
            idx      <= 2'd0;
        end else if (ena) begin
            if (load) begin
                high_cnt <= CNT_W'(1);
                per_cnt  <= CNT_W'(1);
            end else begin
                if (hi_inc) high_cnt <= high_cnt + CNT_W'(1);
                if (per_inc) per_cnt <= per_cnt + CNT_W'(1);
            end
            if (clr_s) begin
                valid  <= 1'b0;
                idx    <= 2'd0;
                ovf    <= 1'b0;
                missed <= 1'b0;
            end else begin
                if (rd_p && valid) begin
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) valid <= 1'b0;
                end
                if (publish) begin
                    if (accept) begin
                        res_high <= 16'(high_cnt);
                        res_per  <= 16'(per_cnt);
                        valid    <= 1'b1;
                    end else begin
                        missed <= 1'b1;
                    end
                end
                if (sat) ovf <= 1'b1;
            end
        end
    end

    always_comb begin
        uo_out = res_high[7:0];
        case (idx)
            2'd0: uo_out = res_high[7:0];
            2'd1: uo_out = res_high[15:8];
            2'd2: uo_out = res_per[7:0];
            2'd3: uo_out = res_per[15:8];
            default: uo_out = res_high[7:0];
        endcase
    end

    assign uio_out = {3'b000, idx, missed, ovf, valid};
    assign uio_oe  = 8'h1F;
endmodule
